// File: rtl/output_channel_tx_pkg.sv
// Shared types and defaults for the router output-channel transmitter.
package output_channel_tx_pkg;

    localparam int DATAW_DEF  = 32;
    localparam int PKTLEN_DEF = 3;
    localparam int CNTW_DEF   = 16;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_GAP  = 2'd2
    } tx_state_e;

    // Width of the flit-within-packet index; never narrower than one bit.
    function automatic int flit_cnt_width(input int pktlen);
        return (pktlen < 1) ? 1 : $clog2(pktlen + 1);
    endfunction

endpackage

// File: rtl/output_channel_tx.sv
// Router output-port transmitter: drains the local output queue and writes
// whole packets into the downstream input FIFO once it has room for one.
module output_channel_tx
    import output_channel_tx_pkg::*;
#(
    parameter int DATAW  = DATAW_DEF,
    parameter int PKTLEN = PKTLEN_DEF,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW:0]   idata,
    input  logic             iempty,
    output logic             rd_en,
    input  logic             dn_ordy,
    output logic [DATAW:0]   odata,
    output logic             owr_en,
    output logic             busy,
    output logic [CNTW-1:0]  pkt_cnt
);

    localparam int FCW = flit_cnt_width(PKTLEN);
    localparam logic [FCW-1:0] TAIL_IDX = FCW'(PKTLEN);

    tx_state_e       state_reg, state_next;
    logic [FCW-1:0]  flit_cnt_reg;
    logic [DATAW:0]  odata_reg;
    logic            owr_en_reg;
    logic [CNTW-1:0] pkt_cnt_reg;
    logic            pop;
    logic            tail_pop;

    // Popping is blocked during reset so an aborted packet loses no queued flit.
    assign pop      = (state_reg == TX_SEND) && !iempty && !rst_;
    assign tail_pop = pop && (flit_cnt_reg == TAIL_IDX);

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_reg <= TX_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // dn_ordy is only consulted at admission; space is reserved for the whole packet.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TX_IDLE: if (dn_ordy && !iempty) state_next = TX_SEND;
            TX_SEND: if (tail_pop)           state_next = TX_GAP;
            TX_GAP:                          state_next = TX_IDLE;
            default:                         state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            odata_reg    <= '0;
            owr_en_reg   <= 1'b0;
            flit_cnt_reg <= '0;
            pkt_cnt_reg  <= '0;
        end else begin
            owr_en_reg <= pop;
            if (pop) begin
                odata_reg    <= idata;
                flit_cnt_reg <= tail_pop ? '0 : flit_cnt_reg + FCW'(1);
            end
            if (tail_pop && (pkt_cnt_reg != '1)) begin
                pkt_cnt_reg <= pkt_cnt_reg + CNTW'(1);
            end
        end
    end

    assign rd_en   = pop;
    assign odata   = odata_reg;
    assign owr_en  = owr_en_reg;
    assign busy    = (state_reg != TX_IDLE);
    assign pkt_cnt = pkt_cnt_reg;

endmodule

// File: tb/tb_output_channel_tx.sv
// Self-checking bench for output_channel_tx: directed vectors, corner sequences
// and randomized traffic checked against a packet-level scoreboard.
module tb_output_channel_tx;

    localparam int DATAW  = 32;
    localparam int PKTLEN = 3;
    localparam int CNTW   = 16;
    localparam int PL     = PKTLEN + 1;

    logic            clk = 1'b0;
    logic            rst_;
    logic            dn_ordy;
    logic [DATAW:0]  idata;
    logic            iempty;
    logic            rd_en;
    logic [DATAW:0]  odata;
    logic            owr_en;
    logic            busy;
    logic [CNTW-1:0] pkt_cnt;

    // Local output-queue FIFO model feeding the DUT
    logic [DATAW:0] fmem [0:4095];
    logic [11:0]    rd_ptr = '0;
    logic [11:0]    wr_ptr = '0;

    assign idata  = fmem[rd_ptr];
    assign iempty = (rd_ptr == wr_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en && !iempty) rd_ptr <= rd_ptr + 12'd1;
    end

    output_channel_tx #(.DATAW(DATAW), .PKTLEN(PKTLEN), .CNTW(CNTW)) dut (
        .clk     (clk),
        .rst_    (rst_),
        .idata   (idata),
        .iempty  (iempty),
        .rd_en   (rd_en),
        .dn_ordy (dn_ordy),
        .odata   (odata),
        .owr_en  (owr_en),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    typedef struct {
        bit              rst;
        bit              ordy;
        bit              push;
        logic [DATAW:0]  pv;
        bit              e_rd;
        bit              e_owr;
        bit              chk_od;
        logic [DATAW:0]  e_od;
        bit              e_busy;
        logic [CNTW-1:0] e_pkt;
    } vec_t;

    vec_t           tv [9];
    int             n_chk  = 0;
    int             n_fail = 0;
    int             cyc_n  = 0;
    bit             log_owr [$];
    logic [DATAW:0] got [$];
    logic [DATAW:0] exp_q [$];
    bit             ordy_at [int];
    int             wcnt;
    int             last_tail;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic chkv(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic push(input logic [DATAW:0] v);
        fmem[wr_ptr] = v;
        wr_ptr = wr_ptr + 12'd1;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        log_owr.push_back(owr_en);
        if (owr_en) begin
            got.push_back(odata);
            $display("cycle %0d: write flit %h pkt_cnt=%0d", cyc_n, odata, pkt_cnt);
        end
    endtask

    task automatic clr();
        log_owr.delete();
        got.delete();
    endtask

    task automatic chk_got(input string nm, input logic [DATAW:0] base, input int n);
        chkv({nm, " count"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            chkv($sformatf("%s flit%0d", nm, i), 64'(got[i]), 64'(base + DATAW'(i)));
        end
    endtask

    // Scoreboard step: order, admission rule, packet spacing, counter and busy.
    task automatic rand_step();
        ordy_at[cyc_n + 1] = dn_ordy;
        cyc();
        if (owr_en) begin
            if (exp_q.size() == 0) begin
                chkv("rnd unexpected write", 64'(odata), 64'(0) - 64'(1));
            end else begin
                chkv("rnd data", 64'(odata), 64'(exp_q.pop_front()));
            end
            if (wcnt % PL == 0) begin
                chk1("rnd admit ordy", ordy_at.exists(cyc_n - 1) ? ordy_at[cyc_n - 1] : 1'b0, 1'b1);
                chk1("rnd spacing", (cyc_n - last_tail) >= 3, 1'b1);
            end
            wcnt++;
            if (wcnt % PL == 0) last_tail = cyc_n;
        end
        chkv("rnd pkt_cnt", 64'(pkt_cnt), 64'(wcnt / PL));
        if ((wcnt % PL != 0) || owr_en) chk1("rnd busy", busy, 1'b1);
    endtask

    initial begin
        int runs, len, last_end;

        // Reset then a single packet A0..A3, cycle by cycle.
        tv[0] = '{1'b1, 1'b1, 1'b1, 33'h0A0, 1'b0, 1'b0, 1'b1, 33'h0,   1'b0, 16'd0};
        tv[1] = '{1'b1, 1'b1, 1'b1, 33'h0A1, 1'b0, 1'b0, 1'b1, 33'h0,   1'b0, 16'd0};
        tv[2] = '{1'b0, 1'b1, 1'b1, 33'h0A2, 1'b0, 1'b0, 1'b1, 33'h0,   1'b1, 16'd0};
        tv[3] = '{1'b0, 1'b1, 1'b1, 33'h0A3, 1'b1, 1'b1, 1'b1, 33'h0A0, 1'b1, 16'd0};
        tv[4] = '{1'b0, 1'b1, 1'b0, 33'h0,   1'b1, 1'b1, 1'b1, 33'h0A1, 1'b1, 16'd0};
        tv[5] = '{1'b0, 1'b1, 1'b0, 33'h0,   1'b1, 1'b1, 1'b1, 33'h0A2, 1'b1, 16'd0};
        tv[6] = '{1'b0, 1'b1, 1'b0, 33'h0,   1'b1, 1'b1, 1'b1, 33'h0A3, 1'b1, 16'd1};
        tv[7] = '{1'b0, 1'b1, 1'b0, 33'h0,   1'b0, 1'b0, 1'b1, 33'h0A3, 1'b0, 16'd1};
        tv[8] = '{1'b0, 1'b1, 1'b0, 33'h0,   1'b0, 1'b0, 1'b1, 33'h0A3, 1'b0, 16'd1};

        for (int i = 0; i < 9; i++) begin
            rst_    = tv[i].rst;
            dn_ordy = tv[i].ordy;
            if (tv[i].push) push(tv[i].pv);
            #1;
            chk1($sformatf("vec%0d rd_en", i), rd_en, tv[i].e_rd);
            cyc();
            chk1($sformatf("vec%0d owr_en", i), owr_en, tv[i].e_owr);
            chk1($sformatf("vec%0d busy", i), busy, tv[i].e_busy);
            chkv($sformatf("vec%0d pkt_cnt", i), 64'(pkt_cnt), 64'(tv[i].e_pkt));
            if (tv[i].chk_od) chkv($sformatf("vec%0d odata", i), 64'(odata), 64'(tv[i].e_od));
        end

        // Back-pressure: 8 flits waiting, downstream not ready.
        dn_ordy = 1'b0;
        for (int i = 0; i < 8; i++) push(33'h0B0 + 33'(i));
        for (int i = 0; i < 10; i++) begin
            #1;
            chk1("bp rd_en held", rd_en, 1'b0);
            cyc();
            chk1("bp owr_en held", owr_en, 1'b0);
        end
        dn_ordy = 1'b1;
        #1;
        chk1("bp rd_en at raise", rd_en, 1'b0);
        cyc();
        chk1("bp rd_en after admit", rd_en, 1'b1);
        clr();
        for (int i = 0; i < 12; i++) cyc();
        chk_got("bp", 33'h0B0, 8);
        chkv("bp pkt_cnt", 64'(pkt_cnt), 64'(3));

        // Bubble: queue runs dry after two flits; dn_ordy drops mid-packet.
        clr();
        push(33'h0C0);
        push(33'h0C1);
        cyc();
        dn_ordy = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        push(33'h0C2);
        push(33'h0C3);
        for (int i = 0; i < 3; i++) cyc();
        begin
            bit pat [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            for (int i = 0; i < 7; i++) chk1($sformatf("bubble owr_en[%0d]", i), log_owr[i + 1], pat[i]);
        end
        chk_got("bubble", 33'h0C0, 4);
        chkv("bubble pkt_cnt", 64'(pkt_cnt), 64'(4));

        // Back-to-back: three packets with minimum spacing.
        clr();
        dn_ordy = 1'b1;
        for (int i = 0; i < 12; i++) push(33'h0E0 + 33'(i));
        for (int i = 0; i < 22; i++) cyc();
        chk_got("b2b", 33'h0E0, 12);
        runs = 0;
        len = 0;
        last_end = 0;
        for (int i = 0; i < log_owr.size(); i++) begin
            if (log_owr[i]) begin
                if (len == 0) begin
                    runs++;
                    if (runs > 1) chkv("b2b gap", 64'(i - last_end - 1), 64'(2));
                end
                len++;
            end else if (len > 0) begin
                chkv("b2b run length", 64'(len), 64'(PL));
                last_end = i - 1;
                len = 0;
            end
        end
        chkv("b2b runs", 64'(runs), 64'(3));
        chkv("b2b pkt_cnt", 64'(pkt_cnt), 64'(7));

        // Mid-packet reset after two flits; the next packet restarts its count.
        clr();
        for (int i = 0; i < 8; i++) push(33'h0D0 + 33'(i));
        for (int i = 0; i < 3; i++) cyc();
        rst_ = 1'b1;
        #1;
        chk1("mrst rd_en", rd_en, 1'b0);
        cyc();
        chk1("mrst owr_en", owr_en, 1'b0);
        chk1("mrst busy", busy, 1'b0);
        chkv("mrst pkt_cnt", 64'(pkt_cnt), 64'(0));
        rst_ = 1'b0;
        for (int i = 0; i < 12; i++) cyc();
        chk_got("mrst", 33'h0D0, 8);
        chkv("mrst pkt_cnt after restart", 64'(pkt_cnt), 64'(1));
        chk1("mrst busy partial", busy, 1'b1);
        push(33'h0D8);
        push(33'h0D9);
        for (int i = 0; i < 4; i++) cyc();
        chkv("mrst pkt_cnt completed", 64'(pkt_cnt), 64'(2));
        chk1("mrst idle", busy, 1'b0);

        // Randomized traffic against the scoreboard.
        rst_ = 1'b1;
        cyc();
        rst_ = 1'b0;
        clr();
        wcnt = 0;
        last_tail = -100;
        for (int k = 0; k < 600; k++) begin
            dn_ordy = (($urandom % 3) != 0);
            if (($urandom % 5) < 2) begin
                logic [DATAW:0] v;
                v = {1'($urandom_range(0, 1)), 32'($urandom)};
                push(v);
                exp_q.push_back(v);
            end
            rand_step();
        end
        dn_ordy = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) rand_step();
        chkv("rnd drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
